// File: rtl/led_flash_arbiter_if.sv
// led_flash_arbiter_if: trigger/hold inputs and LED/status outputs of the flash arbiter
interface led_flash_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0] trigger;
    logic            hold;
    logic            out;
    logic            busy;
    logic [IDW-1:0]  grant_id;
    logic [NREQ-1:0] pending;
    modport master (output trigger, hold, input out, busy, grant_id, pending);
    modport slave  (input trigger, hold, output out, busy, grant_id, pending);
endinterface

// File: rtl/led_flash_arbiter.sv
// led_flash_arbiter: round-robin arbiter blinking source i as i+1 flashes on one shared LED
module led_flash_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int FLASH_W = 19,
    parameter int GAP_W   = 19,
    parameter int PAUSE_W = 21
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    led_flash_arbiter_if.slave bus
);
    localparam int CW = (FLASH_W > GAP_W) ? ((FLASH_W > PAUSE_W) ? FLASH_W : PAUSE_W)
                                          : ((GAP_W > PAUSE_W) ? GAP_W : PAUSE_W);
    localparam int RW = IDW + 1;
    localparam logic [CW-1:0] FLASH_END = CW'({FLASH_W{1'b1}});
    localparam logic [CW-1:0] GAP_END   = CW'({GAP_W{1'b1}});
    localparam logic [CW-1:0] PAUSE_END = CW'({PAUSE_W{1'b1}});

    typedef enum logic [1:0] {IDLE, FLASH, GAP, PAUSE} state_t;

    state_t          r_state, w_nxt;
    logic [CW-1:0]   r_cnt;
    logic [RW-1:0]   r_remain;
    logic [NREQ-1:0] r_trig_ff, r_trig_d, r_pending, w_edge, w_clr;
    logic [IDW-1:0]  r_last, r_grant_id, w_idx, w_j;
    logic            r_out, r_busy, w_found, w_grant, w_dec;

    assign w_edge = r_trig_ff & ~r_trig_d;
    assign w_clr  = w_grant ? ({{(NREQ-1){1'b0}}, 1'b1} << w_idx) : '0;

    // Round-robin search: first pending source after the last one granted
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_j     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_j = IDW'((int'(r_last) + k) % NREQ);
            if (!w_found && r_pending[w_j]) begin
                w_found = 1'b1;
                w_idx   = w_j;
            end
        end
    end

    // Sequencer next state; hold freezes every transition
    always_comb begin
        w_nxt   = r_state;
        w_grant = 1'b0;
        w_dec   = 1'b0;
        if (!bus.hold) begin
            case (r_state)
                IDLE: begin
                    w_grant = w_found;
                    w_nxt   = w_found ? FLASH : IDLE;
                end
                FLASH: begin
                    w_dec = (r_cnt == FLASH_END);
                    w_nxt = !w_dec ? FLASH : (r_remain == RW'(1)) ? PAUSE : GAP;
                end
                GAP:     w_nxt = (r_cnt == GAP_END) ? FLASH : GAP;
                PAUSE:   w_nxt = (r_cnt == PAUSE_END) ? IDLE : PAUSE;
                default: w_nxt = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) r_state <= IDLE;
        else            r_state <= w_nxt;
    end

    // Edge capture, pending latch, phase counter, flash countdown and registered outputs
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_trig_ff  <= '0;
            r_trig_d   <= '0;
            r_pending  <= '0;
            r_cnt      <= '0;
            r_remain   <= '0;
            r_grant_id <= '0;
            r_last     <= IDW'(NREQ - 1);
            r_out      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_trig_ff <= bus.trigger;
            r_trig_d  <= r_trig_ff;
            r_pending <= (r_pending & ~w_clr) | w_edge;
            if (!bus.hold)
                r_cnt <= (r_state == IDLE || w_nxt != r_state) ? '0 : r_cnt + 1'b1;
            if (w_grant) begin
                r_grant_id <= w_idx;
                r_last     <= w_idx;
                r_remain   <= {1'b0, w_idx} + 1'b1;
            end else if (w_dec) begin
                r_remain <= r_remain - 1'b1;
            end
            r_out  <= bus.hold | (r_state == FLASH);
            r_busy <= (r_state != IDLE);
        end
    end

    assign bus.out      = r_out;
    assign bus.busy     = r_busy;
    assign bus.grant_id = r_grant_id;
    assign bus.pending  = r_pending;
endmodule

// File: tb/tb_led_flash_arbiter.sv
// tb_led_flash_arbiter: vector table, corner sequences and random run against a blink-code model
module tb_led_flash_arbiter;
    localparam int NR = 4, IW = 2, FW = 2, GW = 1, PW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    led_flash_arbiter_if #(.NREQ(NR), .IDW(IW)) bus ();

    led_flash_arbiter #(.NREQ(NR), .IDW(IW), .FLASH_W(FW), .GAP_W(GW), .PAUSE_W(PW)) dut (
        .i_clock   (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int rises = 0, cnt_busy = 0, cnt_on = 0;
    bit prev_busy = 1'b0;

    // model: a queue of per-cycle LED levels for the code currently being shown
    logic [NR-1:0] m_ff, m_d, m_pend;
    int m_gid, m_last;
    bit m_out, m_busy;
    bit m_seq[$];

    typedef struct {
        int src;
        int flashes;
        int on_cycles;
        int busy_cycles;
        int latency;
    } vec_t;

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_update();
        logic [NR-1:0] edg, clr;
        bit pf, pb;
        int g;
        if (!rst_n) begin
            m_ff = '0; m_d = '0; m_pend = '0;
            m_gid = 0; m_last = NR - 1;
            m_out = 1'b0; m_busy = 1'b0;
            m_seq.delete();
            return;
        end
        pb = m_seq.size() > 0;
        pf = pb && m_seq[0];
        edg = m_ff & ~m_d;
        clr = '0;
        if (!bus.hold && pb) begin
            void'(m_seq.pop_front());
        end else if (!bus.hold && m_pend != '0) begin
            g = -1;
            for (int k = 1; k <= NR; k++)
                if (g < 0 && m_pend[(m_last + k) % NR]) g = (m_last + k) % NR;
            clr[g] = 1'b1;
            m_gid = g;
            m_last = g;
            for (int f = 0; f <= g; f++) begin
                if (f > 0) repeat (2 ** GW) m_seq.push_back(1'b0);
                repeat (2 ** FW) m_seq.push_back(1'b1);
            end
            repeat (2 ** PW) m_seq.push_back(1'b0);
        end
        m_out = bus.hold | pf;
        m_busy = pb;
        m_pend = (m_pend & ~clr) | edg;
        m_d = m_ff;
        m_ff = bus.trigger;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        chk("model_out", int'(bus.out), int'(m_out));
        chk("model_busy", int'(bus.busy), int'(m_busy));
        chk("model_grant_id", int'(bus.grant_id), m_gid);
        chk("model_pending", int'(bus.pending), int'(m_pend));
        if (bus.busy && !prev_busy) rises++;
        prev_busy = bus.busy;
        cnt_busy += int'(bus.busy);
        cnt_on += int'(bus.out);
    endtask

    task automatic pulse(input logic [NR-1:0] t);
        bus.trigger = t;
        step();
        bus.trigger = '0;
    endtask

    task automatic settle(input int budget);
        int n, quiet;
        n = 0;
        quiet = 0;
        repeat (3) step();
        while (quiet < 2 && n < budget) begin
            step();
            n++;
            quiet = (bus.busy || bus.pending != '0) ? 0 : quiet + 1;
        end
        chk("settle_in_budget", int'(quiet >= 2), 1);
    endtask

    task automatic wait_out(input bit lvl, input string name);
        int n;
        n = 0;
        while (bus.out != lvl && n < 40) begin
            step();
            n++;
        end
        chk(name, int'(bus.out), int'(lvl));
    endtask

    task automatic run_table();
        vec_t tbl[4];
        logic [NR-1:0] t;
        int fl, on, bz, first;
        bit prev;
        tbl[0] = '{0, 1, 4, 12, 3};
        tbl[1] = '{1, 2, 8, 18, 3};
        tbl[2] = '{2, 3, 12, 24, 3};
        tbl[3] = '{3, 4, 16, 30, 3};
        foreach (tbl[v]) begin
            fl = 0; on = 0; bz = 0; first = -1; prev = 1'b0;
            t = '0;
            t[tbl[v].src] = 1'b1;
            pulse(t);
            for (int c = 1; c <= 60; c++) begin
                step();
                if (bus.out) begin
                    on++;
                    if (!prev) fl++;
                    if (first < 0) first = c;
                end
                prev = bus.out;
                if (bus.busy) bz++;
            end
            chk("tbl_flashes", fl, tbl[v].flashes);
            chk("tbl_on_cycles", on, tbl[v].on_cycles);
            chk("tbl_busy_cycles", bz, tbl[v].busy_cycles);
            chk("tbl_latency", first, tbl[v].latency);
            chk("tbl_grant_id", int'(bus.grant_id), tbl[v].src);
        end
    endtask

    task automatic run_drain();
        int exp_p[4] = '{11, 10, 8, 0};
        int exp_g[3] = '{0, 1, 3};
        int exp_f[3] = '{1, 2, 4};
        int pq[$], gq[$], fq[$];
        int last_p, fl;
        bit pb, po;
        last_p = 0; fl = 0; pb = 1'b0; po = 1'b0;
        pulse(4'b1011);
        for (int c = 0; c < 150; c++) begin
            step();
            if (int'(bus.pending) != last_p) begin
                last_p = int'(bus.pending);
                pq.push_back(last_p);
            end
            if (bus.out && !po) fl++;
            if (bus.busy && !pb) gq.push_back(int'(bus.grant_id));
            if (!bus.busy && pb) begin
                fq.push_back(fl);
                fl = 0;
            end
            po = bus.out;
            pb = bus.busy;
        end
        chk("drain_pend_len", pq.size(), 4);
        chk("drain_grant_len", gq.size(), 3);
        chk("drain_code_len", fq.size(), 3);
        for (int i = 0; i < 4; i++) if (i < pq.size()) chk("drain_pending", pq[i], exp_p[i]);
        for (int i = 0; i < 3; i++) if (i < gq.size()) chk("drain_grant", gq[i], exp_g[i]);
        for (int i = 0; i < 3; i++) if (i < fq.size()) chk("drain_flashes", fq[i], exp_f[i]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, b0, o0, hold_left;
        bus.trigger = 4'hF;
        bus.hold = 1'b0;
        rst_n = 1'b0;
        repeat (3) begin
            step();
            chk("rst_out", int'(bus.out), 0);
            chk("rst_busy", int'(bus.busy), 0);
            chk("rst_pending", int'(bus.pending), 0);
        end
        rst_n = 1'b1;
        step();
        bus.trigger = '0;
        step();
        chk("rel_pending_all", int'(bus.pending), 15);
        step();
        chk("rel_first_grant", int'(bus.grant_id), 0);
        chk("rel_pending_after", int'(bus.pending), 14);
        settle(400);

        run_table();
        settle(100);

        run_drain();
        settle(200);

        r0 = rises;
        pulse(4'b0010);
        wait_out(1'b1, "retrig_wait_flash");
        pulse(4'b0010);
        step();
        chk("retrig_pending", int'(bus.pending[1]), 1);
        pulse(4'b0010);
        step();
        pulse(4'b0010);
        settle(200);
        chk("retrig_codes", rises - r0, 2);

        b0 = cnt_busy;
        o0 = cnt_on;
        pulse(4'b0100);
        wait_out(1'b1, "hold_wait_flash");
        wait_out(1'b0, "hold_wait_gap");
        bus.hold = 1'b1;
        repeat (5) begin
            step();
            chk("hold_out", int'(bus.out), 1);
        end
        bus.hold = 1'b0;
        settle(200);
        chk("hold_busy_cycles", cnt_busy - b0, 29);
        chk("hold_on_cycles", cnt_on - o0, 17);

        pulse(4'b1000);
        wait_out(1'b1, "abort_wait_flash");
        rst_n = 1'b0;
        step();
        chk("abort_out", int'(bus.out), 0);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_pending", int'(bus.pending), 0);
        rst_n = 1'b1;
        step();
        r0 = rises;
        pulse(4'b1001);
        for (int n = 0; n < 10 && rises == r0; n++) step();
        chk("abort_rr_restart", int'(bus.grant_id), 0);
        settle(200);

        hold_left = 0;
        for (int c = 0; c < 3000; c++) begin
            bus.trigger = NR'($urandom) & NR'($urandom) & NR'($urandom);
            if (hold_left > 0) hold_left--;
            else if ($urandom_range(0, 59) == 0) hold_left = $urandom_range(1, 6);
            bus.hold = (hold_left > 0);
            rst_n = ($urandom_range(0, 699) != 0);
            step();
        end
        bus.trigger = '0;
        bus.hold = 1'b0;
        rst_n = 1'b1;
        settle(400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
